ultrasonic_ranger: RTL and testbench

Parametrised ultrasonic ranging controller for HC-SR04-class sensors. It generates the trigger pulse, synchronises the echo line and measures the echo pulse width in prescaled ticks. Detection is edge-based, and the block has a timeout, a post-measurement hold-off, and both single-shot and free-running modes. The block sits between the sensor pins and the distance/display logic, and delivers one registered width per measurement with a one-cycle valid strobe.

---
 rtl/ultrasonic_ranger.sv | 127 ++++++++++++
 tb/tb_ultrasonic_ranger.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ranging controller: trigger generation, echo synchronisation and
// echo pulse-width measurement in prescaled ticks, with timeout and hold-off.
module ultrasonic_ranger #(
    parameter int TICK_DIV      = 50,
    parameter int WIDTH         = 16,
    parameter int TRIG_TICKS    = 10,
    parameter int TIMEOUT_TICKS = 30000,
    parameter int HOLDOFF_TICKS = 60000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto_en,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [WIDTH-1:0] width,
    output logic             valid,
    output logic             timeout
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] TRIG_LAST    = WIDTH'(TRIG_TICKS - 1);
    localparam logic [WIDTH-1:0] HOLD_LAST    = WIDTH'(HOLDOFF_TICKS - 1);
    localparam logic [WIDTH-1:0] TIMEOUT_CNT  = WIDTH'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        RESULT,
        HOLDOFF
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic             tick;
    logic             echo_meta, echo_sync, echo_prev;
    logic             rise, fall;
    logic             res_load;
    logic [WIDTH-1:0] res_width;
    logic             res_timeout;

    assign tick    = (presc == PRESC_LAST);
    assign cnt_inc = cnt + WIDTH'(tick);
    assign rise    = echo_sync & ~echo_prev;
    assign fall    = ~echo_sync & echo_prev;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nxt   = state;
        res_load    = 1'b0;
        res_width   = '0;
        res_timeout = 1'b0;
        case (state)
            IDLE:      if (start || auto_en) state_nxt = TRIG;
            TRIG:      if (tick && cnt == TRIG_LAST) state_nxt = WAIT_RISE;
            WAIT_RISE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt   = RESULT;
                    res_load    = 1'b1;
                    res_timeout = 1'b1;
                end
            end
            MEASURE: begin
                // cnt_inc folds in a tick landing on the same edge as the fall
                if (fall) begin
                    state_nxt = RESULT;
                    res_load  = 1'b1;
                    res_width = cnt_inc;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt   = RESULT;
                    res_load    = 1'b1;
                    res_width   = TIMEOUT_CNT;
                    res_timeout = 1'b1;
                end
            end
            RESULT:    state_nxt = HOLDOFF;
            HOLDOFF:   if (tick && cnt == HOLD_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            presc     <= '0;
            cnt       <= '0;
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
            trig      <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            width     <= '0;
            timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every flop samples pre-edge values.
            state     <= state_nxt;
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
            // restarting timebase on each state change keeps durations exact tick multiples
            if (state_nxt != state) begin
                presc <= '0;
                cnt   <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                cnt   <= cnt_inc;
            end
            trig  <= (state_nxt == TRIG);
            busy  <= (state_nxt != IDLE);
            valid <= res_load;
            if (res_load) begin
                width   <= res_width;
                timeout <= res_timeout;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger: randomized echo pulses, a reference
// model feeding a scoreboard queue, and a monitor that checks each valid strobe.
module tb_ultrasonic_ranger;

    localparam int TICK_DIV      = 4;
    localparam int WIDTH         = 8;
    localparam int TRIG_TICKS    = 10;
    localparam int TIMEOUT_TICKS = 100;
    localparam int HOLDOFF_TICKS = 20;
    localparam int TRIG_CYC      = TRIG_TICKS * TICK_DIV;
    localparam int HOLD_CYC      = HOLDOFF_TICKS * TICK_DIV;
    localparam int NOECHO_CYC    = TIMEOUT_TICKS * TICK_DIV + 1;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             start   = 1'b0;
    logic             auto_en = 1'b0;
    logic             echo    = 1'b0;
    logic             trig, busy, valid, timeout;
    logic [WIDTH-1:0] width;

    ultrasonic_ranger #(
        .TICK_DIV      (TICK_DIV),
        .WIDTH         (WIDTH),
        .TRIG_TICKS    (TRIG_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .HOLDOFF_TICKS (HOLDOFF_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .auto_en (auto_en),
        .echo    (echo),
        .trig    (trig),
        .busy    (busy),
        .width   (width),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        bit to;
    } result_t;

    result_t exp_q[$];
    result_t mon_exp;
    int      checks      = 0;
    int      failures    = 0;
    int      cyc         = 0;
    int      valid_count = 0;
    int      trig_rises  = 0;
    logic    prev_valid  = 1'b0;
    logic    prev_trig   = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: width is whole ticks of echo-high time; no rise -> 0/timeout,
    // echo that never falls -> capped at TIMEOUT_TICKS with timeout.
    function automatic result_t model(input bit rise_seen, input int high);
        result_t r;
        if (!rise_seen) begin
            r.w  = 0;
            r.to = 1'b1;
        end else if (high < 0) begin
            r.w  = TIMEOUT_TICKS;
            r.to = 1'b1;
        end else begin
            r.w  = high / TICK_DIV;
            r.to = 1'b0;
        end
        return r;
    endfunction

    // Monitor: pops one expectation per valid strobe.
    always @(negedge clk) begin
        if (reset && valid) begin
            check("valid_one_cycle", prev_valid, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("width", width, mon_exp.w);
                check("timeout", timeout, mon_exp.to);
            end
            if (!prev_valid) valid_count <= valid_count + 1;
        end
        if (trig && !prev_trig) trig_rises <= trig_rises + 1;
        prev_valid <= valid;
        prev_trig  <= trig;
    end

    // Bounded wait from a negedge: which 0=trig, 1=valid, 2=busy. at = cycle seen, -1 on expiry.
    task automatic wait_sig(input string name, input int which, input logic level,
                            input int limit, output int at);
        logic s;
        at = -1;
        for (int n = 0; n <= limit; n++) begin
            case (which)
                0:       s = trig;
                1:       s = valid;
                default: s = busy;
            endcase
            if (s === level) begin
                at = cyc;
                return;
            end
            if (n == limit) check(name, s, level);
            else @(negedge clk);
        end
    endtask

    // One single-shot measurement. delay<0: no echo; high<0: echo stays high;
    // pre_high: echo raised during TRIG so it is already high at WAIT_RISE entry.
    task automatic single(input int delay, input int high, input bit pre_high);
        int c_start, t_rise, t_fall, e_fall, t_v, t_vl, t_b;
        bit rise_seen;
        rise_seen = (delay >= 0) && !pre_high;
        exp_q.push_back(model(rise_seen, high));
        e_fall  = -1;
        start   = 1'b1;
        c_start = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_sig("trig_rise", 0, 1'b1, 4, t_rise);
        check("trig_start_latency", t_rise - c_start, 1);
        if (pre_high) echo = 1'b1;
        wait_sig("trig_fall", 0, 1'b0, TRIG_CYC + 4, t_fall);
        check("trig_len", t_fall - t_rise, TRIG_CYC);
        if (rise_seen) begin
            repeat (delay) @(negedge clk);
            echo = 1'b1;
            if (high >= 0) begin
                repeat (high) @(negedge clk);
                echo   = 1'b0;
                e_fall = cyc;
            end
        end
        wait_sig("valid_rise", 1, 1'b1, 2 * NOECHO_CYC, t_v);
        if (e_fall >= 0) check("fall_to_valid", t_v - e_fall, 3);
        else if (!rise_seen) check("noecho_to_valid", t_v - t_fall, NOECHO_CYC);
        echo = 1'b0;
        @(negedge clk);
        wait_sig("valid_fall", 1, 1'b0, 2, t_vl);
        check("valid_len", t_vl - t_v, 1);
        wait_sig("busy_fall", 2, 1'b0, HOLD_CYC + 8, t_b);
        check("holdoff_len", t_b - t_vl, HOLD_CYC);
    endtask

    initial begin
        int t, base, vcount0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check("reset_trig", trig, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", valid, 1'b0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_width", width, 0);

        single(30, 200, 1'b0);
        single(-1, 0, 1'b0);
        single(30, -1, 1'b0);
        single(0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            single(int'($urandom_range(5, 300)), int'($urandom_range(8, 380)), 1'b0);
        end

        // Free-running mode with extra start pulses that must be dropped.
        base    = trig_rises;
        auto_en = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < 3; m++) begin
            exp_q.push_back(model(1'b1, 40));
            wait_sig("auto_trig_rise", 0, 1'b1, HOLD_CYC + 10, t);
            wait_sig("auto_trig_fall", 0, 1'b0, TRIG_CYC + 4, t);
            if (m == 2) auto_en = 1'b0;
            repeat ($urandom_range(5, 50)) @(negedge clk);
            echo  = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (39) @(negedge clk);
            echo = 1'b0;
            wait_sig("auto_valid_rise", 1, 1'b1, 20, t);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_sig("auto_busy_fall", 2, 1'b0, HOLD_CYC + 8, t);
        repeat (100) @(negedge clk);
        check("auto_trig_count", trig_rises - base, 3);
        check("auto_stays_idle", busy, 1'b0);

        // Asynchronous reset in the middle of MEASURE.
        vcount0 = valid_count;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sig("rst_trig_fall", 0, 1'b0, TRIG_CYC + 6, t);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_trig", trig, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_width", width, 0);
        check("rst_timeout", timeout, 1'b0);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_strobe", valid_count - vcount0, 0);
        check("rst_idle_after_release", busy, 1'b0);
        single(30, 120, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
